// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryptor (FIPS-197) for 128/192/256-bit keys.
// The key is expanded once into a round-key store, one word per cycle.
// Blocks are then encrypted one round per clock, one block in flight.
module aes_encrypt_iter #(
   parameter int KEY_BITS = 128
) (
   input  logic                Clock,
   input  logic                ResetN,
   input  logic [KEY_BITS-1:0] CipherKey,
   input  logic                KeyValid,
   output logic                KeyReady,
   input  logic [127:0]        InputMessage,
   input  logic                InValid,
   output logic                InReady,
   output logic [127:0]        CodedMessage,
   output logic                OutValid,
   input  logic                OutReady
);

   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);

   if (!((KEY_BITS == 128) || (KEY_BITS == 192) || (KEY_BITS == 256))) begin : g_bad_key_bits
      $error("aes_encrypt_iter: KEY_BITS must be 128, 192 or 256");
   end

   typedef enum logic [2:0] {
      S_NOKEY  = 3'd0,
      S_EXPAND = 3'd1,
      S_IDLE   = 3'd2,
      S_ROUND  = 3'd3,
      S_DONE   = 3'd4
   } state_e;

   // GF(2^8) multiply by x, modulo x^8+x^4+x^3+x+1 (0x11B)
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         p  = p ^ (b[k] ? aa : 8'h00);
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box: multiplicative inverse as a^254 (0 maps to 0), then the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] sq;
      logic [7:0] e;
      e  = 8'hFE;
      r  = 8'h01;
      sq = a;
      for (int k = 0; k < 8; k++) begin
         r  = e[k] ? gf_mul(r, sq) : r;
         sq = gf_mul(sq, sq);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // One cipher round; the final round leaves out MixColumns
   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
      logic [127:0] sb;
      logic [127:0] sr;
      logic [127:0] mc;
      for (int n = 0; n < 16; n++) begin
         sb[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
      end
      return (last ? sr : mc) ^ rk;
   endfunction

   state_e         state_q, state_d;
   logic [127:0]   data_q, data_d;
   logic [127:0]   coded_q, coded_d;
   logic [3:0]     round_q, round_d;
   logic [5:0]     widx_q, widx_d;
   logic [2:0]     kmod_q, kmod_d;
   logic [7:0]     rcon_q, rcon_d;
   logic           key_ready_q, key_ready_d;
   logic [31:0]    w_q [NW];

   logic           key_accept_s;
   logic           in_ready_s;
   logic [31:0]    prev_s, old_s, temp_s, new_word_s;
   logic [3:0]     rk_idx_s;
   logic [5:0]     rk_base_s;
   logic [127:0]   rk_s;
   logic [127:0]   round_out_s;

   assign key_accept_s = KeyValid & key_ready_q;
   assign in_ready_s   = (state_q == S_IDLE) & ~KeyValid;

   // Next key-schedule word w[i] from w[i-1] and w[i-NK]
   always_comb begin
      prev_s = w_q[widx_q - 6'd1];
      old_s  = w_q[widx_q - 6'(NK)];
      if (kmod_q == 3'd0) begin
         temp_s = sub_word({prev_s[23:0], prev_s[31:24]}) ^ {rcon_q, 24'h000000};
      end else if ((NK == 8) && (kmod_q == 3'd4)) begin
         temp_s = sub_word(prev_s);
      end else begin
         temp_s = prev_s;
      end
      new_word_s = old_s ^ temp_s;
   end

   // Round key for the current round (round 0 while idle) and the round result
   always_comb begin
      rk_idx_s    = (state_q == S_ROUND) ? round_q : 4'd0;
      rk_base_s   = {rk_idx_s, 2'b00};
      rk_s        = {w_q[rk_base_s], w_q[rk_base_s + 6'd1],
                     w_q[rk_base_s + 6'd2], w_q[rk_base_s + 6'd3]};
      round_out_s = aes_round(data_q, rk_s, (round_q == 4'(NR)));
   end

   // FSM next state and datapath next values
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      coded_d = coded_q;
      round_d = round_q;
      widx_d  = widx_q;
      kmod_d  = kmod_q;
      rcon_d  = rcon_q;
      case (state_q)
         S_NOKEY: begin
            if (key_accept_s) begin
               state_d = S_EXPAND;
               widx_d  = 6'(NK);
               kmod_d  = 3'd0;
               rcon_d  = 8'h01;
            end else begin
               state_d = S_NOKEY;
            end
         end
         S_EXPAND: begin
            widx_d = widx_q + 6'd1;
            if (kmod_q == 3'(NK - 1)) begin
               kmod_d = 3'd0;
            end else begin
               kmod_d = kmod_q + 3'd1;
            end
            if (kmod_q == 3'd0) begin
               rcon_d = xtime(rcon_q);
            end else begin
               rcon_d = rcon_q;
            end
            if (widx_q == 6'(NW - 1)) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_EXPAND;
            end
         end
         S_IDLE: begin
            if (key_accept_s) begin
               state_d = S_EXPAND;
               widx_d  = 6'(NK);
               kmod_d  = 3'd0;
               rcon_d  = 8'h01;
            end else if (InValid && in_ready_s) begin
               state_d = S_ROUND;
               data_d  = InputMessage ^ rk_s;
               round_d = 4'd1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ROUND: begin
            if (round_q == 4'(NR)) begin
               coded_d = round_out_s;
               state_d = S_DONE;
            end else begin
               data_d  = round_out_s;
               round_d = round_q + 4'd1;
               state_d = S_ROUND;
            end
         end
         S_DONE: begin
            if (OutReady) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_NOKEY;
         end
      endcase
      key_ready_d = (state_d == S_NOKEY) || (state_d == S_IDLE);
   end

   // Control and datapath registers; reset aborts any key or block in progress
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q     <= S_NOKEY;
         data_q      <= 128'h0;
         coded_q     <= 128'h0;
         round_q     <= 4'd0;
         widx_q      <= 6'd0;
         kmod_q      <= 3'd0;
         rcon_q      <= 8'h01;
         key_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         coded_q     <= coded_d;
         round_q     <= round_d;
         widx_q      <= widx_d;
         kmod_q      <= kmod_d;
         rcon_q      <= rcon_d;
         key_ready_q <= key_ready_d;
      end
   end

   // Round-key store: key words on accept, then one expanded word per EXPAND cycle
   always_ff @(posedge Clock) begin
      if (key_accept_s) begin
         for (int j = 0; j < NK; j++) begin
            w_q[j] <= CipherKey[KEY_BITS-1-32*j -: 32];
         end
      end else if (state_q == S_EXPAND) begin
         w_q[widx_q] <= new_word_s;
      end
   end

   assign KeyReady     = key_ready_q;
   assign InReady      = in_ready_s;
   assign OutValid     = (state_q == S_DONE);
   assign CodedMessage = coded_q;

endmodule
